jtframe_romrq: RTL and testbench

JTFRAME_ROMRQ -- requirements
Module: jtframe_romrq

---
 rtl/jtframe_romrq.sv | 142 ++++++++++++++
 tb/tb_jtframe_romrq.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtframe_romrq.sv
// jtframe_romrq: read-only SDRAM slot front-end with a one- or two-line cache.
// Each fetch brings in a 32-bit line (two 16-bit SDRAM words at an even word
// address), so neighbouring slot addresses are served without a new request.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   clr               synchronous cache invalidate
//   offset            SDRAM word offset added to every request address
//   addr, addr_ok     slot address (DW-sized units) and chip select
//   sdram_addr, req   request word address and fetch request to the arbiter
//   din, dst, din_ok  SDRAM burst data: low word strobe, high word / done strobe
//   we                this slot owns the current burst
//   data_ok, dout     read data and its valid flag
module jtframe_romrq #(
  parameter int SDRAMW  = 22,
  parameter int AW      = 18,
  parameter int DW      = 8,
  parameter int LATCH   = 0,
  parameter int DOUBLE  = 0,
  parameter int OKLATCH = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic [SDRAMW-1:0] offset,
  input  logic [AW-1:0]     addr,
  input  logic              addr_ok,
  output logic [SDRAMW-1:0] sdram_addr,
  input  logic [15:0]       din,
  input  logic              dst,
  input  logic              din_ok,
  input  logic              we,
  output logic              req,
  output logic              data_ok,
  output logic [DW-1:0]     dout
);

  localparam int TW = SDRAMW - 1;

  logic [TW-1:0] tag;
  logic [31:0]   line;
  logic [DW-1:0] dsel;

  logic [1:0]    valid_q, valid_d;
  logic [TW-1:0] tag_q  [2];
  logic [31:0]   data_q [2];
  logic [15:0]   low_q;
  logic          ptr_q;
  logic          victim, fill, hit0, hit1, hit;

  // Line tag and the DW-sized slice of the line addressed by addr.
  generate
    if (DW == 8) begin : g_dw8
      assign tag  = TW'(addr >> 2);
      assign dsel = line[{addr[1:0], 3'd0} +: 8];
    end else if (DW == 16) begin : g_dw16
      assign tag  = TW'(addr >> 1);
      assign dsel = line[{addr[0], 4'd0} +: 16];
    end else begin : g_dw32
      assign tag  = TW'(addr);
      assign dsel = line;
    end
  endgenerate

  assign sdram_addr = offset + {tag, 1'b0};

  assign hit0   = valid_q[0] && (tag_q[0] == tag);
  assign hit1   = valid_q[1] && (tag_q[1] == tag);
  assign hit    = addr_ok && (hit0 || hit1);
  assign line   = hit0 ? data_q[0] : data_q[1];
  assign fill   = we && din_ok;
  // Single-entry cache always refills entry 0; entry 1 then never becomes valid.
  assign victim = (DOUBLE != 0) ? ptr_q : 1'b0;
  assign req    = addr_ok && !hit && !fill;

  // clr wipes every entry, but a fill landing in the same cycle survives.
  always_comb begin
    valid_d = clr ? '0 : valid_q;
    if (fill) valid_d[victim] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      low_q   <= '0;
      ptr_q   <= 1'b0;
      for (int unsigned i = 0; i < 2; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      if (we && dst) low_q <= din;
      if (fill) begin
        tag_q[victim]  <= tag;
        data_q[victim] <= {din, low_q};
        if (DOUBLE != 0) ptr_q <= ~ptr_q;
      end
    end
  end

  generate
    if (LATCH != 0) begin : g_dout_reg
      logic [DW-1:0] dout_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)      dout_q <= '0;
        else if (hit) dout_q <= dsel;
      end
      assign dout = dout_q;
    end else begin : g_dout_comb
      assign dout = dsel;
    end
  endgenerate

  generate
    if (OKLATCH == 0) begin : g_ok_comb
      assign data_ok = hit;
    end else if (LATCH != 0) begin : g_ok_lat
      logic ok_q, ok2_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ok_q  <= 1'b0;
          ok2_q <= 1'b0;
        end else begin
          ok_q  <= hit;
          ok2_q <= ok_q;
        end
      end
      // ok2_q aligns with the registered dout; ANDing ok_q drops the flag
      // one cycle after an address change instead of two.
      assign data_ok = addr_ok && ok_q && ok2_q;
    end else begin : g_ok_reg
      logic ok_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) ok_q <= 1'b0;
        else     ok_q <= hit;
      end
      assign data_ok = addr_ok && ok_q;
    end
  endgenerate

endmodule

// File: tb/tb_jtframe_romrq.sv
// Bench for jtframe_romrq: three configurations driven one at a time,
// checked against a line-cache model built from tags, ways and byte offsets.
//   u0: DW=8,  one entry,  OKLATCH=1, LATCH=0  (data_ok one cycle after fill)
//   u1: DW=32, two entries, OKLATCH=0, LATCH=0 (data_ok at the fill edge)
//   u2: DW=16, two entries, OKLATCH=1, LATCH=1 (data_ok two cycles after fill)
module tb_jtframe_romrq;

  logic        clk = 1'b0;
  logic        rst, clr, dst, din_ok;
  logic [21:0] offset;
  logic [15:0] din;
  logic [17:0] addr_v [3];
  logic        aok_v  [3];
  logic        we_v   [3];
  logic        req_v  [3];
  logic        ok_v   [3];
  logic [21:0] sa_v   [3];
  logic [7:0]  dout0;
  logic [31:0] dout1;
  logic [15:0] dout2;

  int n_checks = 0;
  int n_pass   = 0;

  // model state
  bit          mvalid [3][2];
  logic [20:0] mtag   [3][2];
  logic [31:0] mdata  [3][2];
  bit          mptr   [3];

  int ex_a [4] = '{5, 4, 6, 7};
  int ex_b [4] = '{'h34, 'h12, 'h56, 'h78};

  always #5 clk = ~clk;

  jtframe_romrq #(.SDRAMW(22), .AW(18), .DW(8), .LATCH(0), .DOUBLE(0), .OKLATCH(1)) u0 (
    .clk(clk), .rst(rst), .clr(clr), .offset(offset), .addr(addr_v[0]), .addr_ok(aok_v[0]),
    .sdram_addr(sa_v[0]), .din(din), .dst(dst), .din_ok(din_ok), .we(we_v[0]),
    .req(req_v[0]), .data_ok(ok_v[0]), .dout(dout0));

  jtframe_romrq #(.SDRAMW(22), .AW(18), .DW(32), .LATCH(0), .DOUBLE(1), .OKLATCH(0)) u1 (
    .clk(clk), .rst(rst), .clr(clr), .offset(offset), .addr(addr_v[1]), .addr_ok(aok_v[1]),
    .sdram_addr(sa_v[1]), .din(din), .dst(dst), .din_ok(din_ok), .we(we_v[1]),
    .req(req_v[1]), .data_ok(ok_v[1]), .dout(dout1));

  jtframe_romrq #(.SDRAMW(22), .AW(18), .DW(16), .LATCH(1), .DOUBLE(1), .OKLATCH(1)) u2 (
    .clk(clk), .rst(rst), .clr(clr), .offset(offset), .addr(addr_v[2]), .addr_ok(aok_v[2]),
    .sdram_addr(sa_v[2]), .din(din), .dst(dst), .din_ok(din_ok), .we(we_v[2]),
    .req(req_v[2]), .data_ok(ok_v[2]), .dout(dout2));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic int unsigned dw_of(input int k);
    case (k)
      0:       return 8;
      1:       return 32;
      default: return 16;
    endcase
  endfunction

  function automatic bit dbl_of(input int k);
    return k != 0;
  endfunction

  function automatic int lat_of(input int k);
    case (k)
      0:       return 1;
      1:       return 0;
      default: return 2;
    endcase
  endfunction

  function automatic logic [20:0] m_tag(input int k, input logic [17:0] a);
    longint w;
    case (dw_of(k))
      8:       w = longint'(a) / 2;
      16:      w = longint'(a);
      default: w = longint'(a) * 2;
    endcase
    return 21'(w / 2);
  endfunction

  function automatic logic [21:0] m_sa(input int k, input logic [17:0] a);
    longint s;
    s = longint'(offset) + 2 * longint'(m_tag(k, a));
    return 22'(s % 64'd4194304);
  endfunction

  function automatic int m_way(input int k, input logic [17:0] a);
    int r;
    r = -1;
    for (int i = 0; i < 2; i++)
      if (mvalid[k][i] && mtag[k][i] == m_tag(k, a)) r = i;
    return r;
  endfunction

  function automatic logic [31:0] m_dout(input int k, input logic [17:0] a, input logic [31:0] ln);
    int unsigned sh;
    case (dw_of(k))
      8: begin
        sh = 8 * (int'(a) % 4);
        return (ln >> sh) & 32'hFF;
      end
      16: begin
        sh = 16 * (int'(a) % 2);
        return (ln >> sh) & 32'hFFFF;
      end
      default: return ln;
    endcase
  endfunction

  function automatic logic [31:0] dout_of(input int k);
    case (k)
      0:       return {24'd0, dout0};
      1:       return dout1;
      default: return {16'd0, dout2};
    endcase
  endfunction

  task automatic m_clr_all();
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 2; i++) mvalid[k][i] = 1'b0;
  endtask

  task automatic m_reset_all();
    m_clr_all();
    for (int k = 0; k < 3; k++) mptr[k] = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clr();
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    m_clr_all();
  endtask

  // Present address a to slot k, check lookup, and on a miss run a burst.
  task automatic access(input int k, input logic [17:0] a, input logic [15:0] lo,
                        input logic [15:0] hi, input bit clrfill);
    int way, gap, lat;
    lat = lat_of(k);
    addr_v[k] = a;
    aok_v[k]  = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    way = m_way(k, a);
    check_eq("req", req_v[k], way < 0);
    check_eq("sdram_addr", sa_v[k], m_sa(k, a));
    if (way >= 0) begin
      check_eq("data_ok_hit", ok_v[k], 1);
      check_eq("dout_hit", dout_of(k), m_dout(k, a, mdata[k][way]));
    end else begin
      check_eq("data_ok_miss", ok_v[k], 0);
      tick();
      we_v[k] = 1'b1;
      dst     = 1'b1;
      din     = lo;
      tick();
      dst = 1'b0;
      din = 16'($urandom);
      gap = $urandom_range(0, 2);
      repeat (gap) tick();
      din_ok = 1'b1;
      din    = hi;
      clr    = clrfill;
      @(negedge clk);
      check_eq("req_fill", req_v[k], 0);
      tick();
      we_v[k] = 1'b0;
      din_ok  = 1'b0;
      clr     = 1'b0;
      din     = 16'($urandom);
      if (clrfill) m_clr_all();
      way = dbl_of(k) ? int'(mptr[k]) : 0;
      mvalid[k][way] = 1'b1;
      mtag[k][way]   = m_tag(k, a);
      mdata[k][way]  = {hi, lo};
      if (dbl_of(k)) mptr[k] = ~mptr[k];
      for (int i = 0; i <= lat; i++) begin
        @(negedge clk);
        check_eq("data_ok_lat", ok_v[k], i >= lat);
        if (i == lat) begin
          check_eq("dout_fill", dout_of(k), m_dout(k, a, mdata[k][way]));
          check_eq("req_after_fill", req_v[k], 0);
        end else begin
          tick();
        end
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; clr = 1'b0; dst = 1'b0; din_ok = 1'b0; din = '0; offset = '0;
    for (int k = 0; k < 3; k++) begin
      addr_v[k] = '0; aok_v[k] = 1'b0; we_v[k] = 1'b0;
    end
    m_reset_all();
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check_eq("reset_req", req_v[k], 0);
      check_eq("reset_data_ok", ok_v[k], 0);
    end
    check_eq("reset_dout", dout2, 0);
    rst = 1'b0;
    tick();

    // DW=8 example line, then neighbouring bytes of the same line
    offset = 22'h100;
    for (int i = 0; i < 4; i++) begin
      access(0, 18'(ex_a[i]), 16'h3412, 16'h7856, 1'b0);
      check_eq("ex8_sdram_addr", sa_v[0], 22'h102);
      check_eq("ex8_dout", dout0, 32'(ex_b[i]));
      check_eq("ex8_data_ok", ok_v[0], 1);
    end
    aok_v[0] = 1'b0;

    // DW=32 example
    offset = '0;
    access(1, 18'd3, 16'hBBBB, 16'hAAAA, 1'b0);
    check_eq("ex32_sdram_addr", sa_v[1], 22'd6);
    check_eq("ex32_dout", dout1, 32'hAAAABBBB);

    // two-entry cache keeps A after B
    access(1, 18'd0, 16'h1111, 16'h2222, 1'b0);
    access(1, 18'd1, 16'h3333, 16'h4444, 1'b0);
    access(1, 18'd0, 16'h0, 16'h0, 1'b0);
    check_eq("double_keeps_a", req_v[1], 0);
    aok_v[1] = 1'b0;

    // one-entry cache evicts A after B
    access(0, 18'h200, 16'h5555, 16'h6666, 1'b0);
    access(0, 18'h204, 16'h7777, 16'h8888, 1'b0);
    addr_v[0] = 18'h200;
    @(negedge clk);
    check_eq("single_evicts_a", req_v[0], 1);
    access(0, 18'h200, 16'h9999, 16'hAAAA, 1'b0);

    // clr invalidates, then clr coincident with a fill keeps the new line
    pulse_clr();
    @(negedge clk);
    check_eq("req_after_clr", req_v[0], 1);
    access(0, 18'h200, 16'h1357, 16'h2468, 1'b1);
    access(0, 18'h201, 16'h0, 16'h0, 1'b0);
    check_eq("clr_fill_survives", req_v[0], 0);

    // asynchronous reset in the middle of a burst
    addr_v[0] = 18'h300;
    tick();
    we_v[0] = 1'b1; dst = 1'b1; din = 16'hDEAD;
    tick();
    dst = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_eq("rst_data_ok", ok_v[0], 0);
    @(negedge clk);
    rst = 1'b0;
    we_v[0] = 1'b0;
    m_reset_all();
    addr_v[0] = 18'h201;
    tick();
    @(negedge clk);
    check_eq("rst_invalidates", req_v[0], 1);
    tick();
    din_ok = 1'b1; din = 16'hBEEF;
    tick();
    din_ok = 1'b0;
    @(negedge clk);
    check_eq("din_ok_no_we_req", req_v[0], 1);
    check_eq("din_ok_no_we_ok", ok_v[0], 0);
    access(0, 18'h201, 16'hCAFE, 16'hF00D, 1'b0);
    aok_v[0] = 1'b0;

    // randomized traffic per configuration
    for (int k = 0; k < 3; k++) begin
      offset = (k == 1) ? 22'h3FFFF0 : 22'($urandom);
      for (int n = 0; n < 20; n++) begin
        if ($urandom_range(0, 7) == 0) pulse_clr();
        access(k, 18'($urandom_range(0, 15)) + 18'h1000, 16'($urandom), 16'($urandom),
               $urandom_range(0, 9) == 0);
      end
      aok_v[k] = 1'b0;
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
